// File: rtl/alexnet_pkg.sv
// alexnet_pkg: shared pixel type, argmax position codes and unsigned max helpers.
package alexnet_pkg;
  localparam int DATA_W = 16;
  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } rgb_t;
  localparam logic [1:0] POS_TL = 2'd0;
  localparam logic [1:0] POS_TR = 2'd1;
  localparam logic [1:0] POS_BL = 2'd2;
  localparam logic [1:0] POS_BR = 2'd3;
  // y replaces x only when strictly greater, so the earlier pixel wins ties.
  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    return (y > x) ? y : x;
  endfunction
  function automatic rgb_t rgb_max(input rgb_t x, input rgb_t y);
    return '{r: umax(x.r, y.r), g: umax(x.g, y.g), b: umax(x.b, y.b)};
  endfunction
  function automatic logic [2:0] rgb_gt(input rgb_t x, input rgb_t y);
    return {y.b > x.b, y.g > x.g, y.r > x.r};
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: top-row partial maxima; synchronous write, combinational read.
module pool_line_buf #(
  parameter int W     = 48,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2 stride-2 RGB max-pool; MAXPOOL_ARGMAX_EN adds pool_idx.
module maxpool_2x2 import alexnet_pkg::*; #(
  parameter int DATA_W = alexnet_pkg::DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ack,
  input  logic              clr,
  input  logic [DATA_W-1:0] Pool_in_R,
  input  logic [DATA_W-1:0] Pool_in_G,
  input  logic [DATA_W-1:0] Pool_in_B,
  output logic [DATA_W-1:0] Pool_o_R,
  output logic [DATA_W-1:0] Pool_o_G,
  output logic [DATA_W-1:0] Pool_o_B,
  output logic              pool_ack,
  output logic              frame_done
`ifdef MAXPOOL_ARGMAX_EN
  ,
  output logic [5:0]        pool_idx
`endif
);
  if (IMG_W < 2 || IMG_W % 2 != 0 || IMG_H < 2 || IMG_H % 2 != 0 || DATA_W != alexnet_pkg::DATA_W) begin : g_bad_cfg
    $error("maxpool_2x2: IMG_W/IMG_H must be even and >= 2, DATA_W must match alexnet_pkg");
  end
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int AW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam int PW = $bits(rgb_t);
`ifdef MAXPOOL_ARGMAX_EN
  localparam int LB_W = PW + 3;
`else
  localparam int LB_W = PW;
`endif
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  rgb_t          r_hold, r_out;
  logic          r_ack, r_done;
  rgb_t          w_in, w_row, w_top, w_out;
  logic [LB_W-1:0] w_wdata, w_rdata;
  logic          w_take, w_emit, w_we, w_last_col, w_last_row;
  assign w_in       = '{r: Pool_in_R, g: Pool_in_G, b: Pool_in_B};
  assign w_take     = ack & ~clr;
  assign w_emit     = w_take & r_col[0] & r_row[0];
  assign w_we       = w_take & r_col[0] & ~r_row[0] & ~rst;
  assign w_last_col = r_col == CW'(IMG_W - 1);
  assign w_last_row = r_row == RW'(IMG_H - 1);
  assign w_row      = rgb_max(r_hold, w_in);
  assign w_top      = w_rdata[PW-1:0];
  // Raster order inside the window: top row (TL/TR), then BL (hold), then BR (input).
  assign w_out      = rgb_max(rgb_max(w_top, r_hold), w_in);
  pool_line_buf #(.W(LB_W), .DEPTH(IMG_W / 2), .AW(AW)) u_lb (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (AW'(r_col >> 1)),
    .i_wdata (w_wdata),
    .i_raddr (AW'(r_col >> 1)),
    .o_rdata (w_rdata)
  );
`ifdef MAXPOOL_ARGMAX_EN
  logic [5:0] r_idx, w_idx;
  logic [2:0] w_gt1, w_gt2, w_top_bits;
  assign w_wdata    = {rgb_gt(r_hold, w_in), w_row};
  assign w_top_bits = w_rdata[LB_W-1 -: 3];
  assign w_gt1      = rgb_gt(w_top, r_hold);
  assign w_gt2      = rgb_gt(rgb_max(w_top, r_hold), w_in);
  always_comb begin
    w_idx = '0;
    for (int c = 0; c < 3; c++)
      w_idx[2*c +: 2] = w_gt2[c] ? POS_BR : w_gt1[c] ? POS_BL : w_top_bits[c] ? POS_TR : POS_TL;
  end
  assign pool_idx = r_idx;
`else
  assign w_wdata = w_row;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_hold <= '0;
      r_out  <= '0;
      r_ack  <= 1'b0;
      r_done <= 1'b0;
`ifdef MAXPOOL_ARGMAX_EN
      r_idx  <= '0;
`endif
    end else begin
      r_ack  <= w_emit;
      r_done <= w_emit & w_last_row & w_last_col;
      if (w_emit) r_out <= w_out;
`ifdef MAXPOOL_ARGMAX_EN
      if (w_emit) r_idx <= w_idx;
`endif
      if (w_take & ~r_col[0]) r_hold <= w_in;
      if (clr) begin
        r_col <= '0;
        r_row <= '0;
      end else if (ack) begin
        r_col <= w_last_col ? '0 : r_col + 1'b1;
        if (w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
      end
    end
  end
  assign Pool_o_R   = r_out.r;
  assign Pool_o_G   = r_out.g;
  assign Pool_o_B   = r_out.b;
  assign pool_ack   = r_ack;
  assign frame_done = r_done;
endmodule

// File: tb/tb_maxpool_2x2.sv
// tb_maxpool_2x2: directed scoreboard bench for a 4x4 maxpool_2x2 (also covers MAXPOOL_ARGMAX_EN builds).
module tb_maxpool_2x2;
  localparam int W = 4;
  localparam int H = 4;
  logic clk = 1'b0;
  logic rst, ack, clr;
  logic [15:0] in_r, in_g, in_b, o_r, o_g, o_b;
  logic pool_ack, frame_done;
`ifdef MAXPOOL_ARGMAX_EN
  logic [5:0] pool_idx;
`endif
  maxpool_2x2 #(.DATA_W(16), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .ack        (ack),
    .clr        (clr),
    .Pool_in_R  (in_r),
    .Pool_in_G  (in_g),
    .Pool_in_B  (in_b),
    .Pool_o_R   (o_r),
    .Pool_o_G   (o_g),
    .Pool_o_B   (o_b),
    .pool_ack   (pool_ack),
    .frame_done (frame_done)
`ifdef MAXPOOL_ARGMAX_EN
    ,
    .pool_idx   (pool_idx)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0][15:0] v;
    logic [2:0][1:0]  idx;
    logic             fd;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int mc = 0;
  int mr = 0;
  logic [15:0] px [3][H][W];
  logic [15:0] tp [16] = '{1, 5, 2, 3, 4, 0, 9, 9, 0, 0, 0, 0, 7, 7, 0, 1};
  logic [15:0] am [16] = '{3, 3, 1, 2, 3, 2, 8, 8, 5, 5, 5, 5, 0, 9, 9, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden model: stores the frame, picks each window max scanning TL,TR,BL,BR with strict >.
  task automatic model_px(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b, output logic comp);
    exp_t e;
    logic [15:0] best, v;
    comp = (mc % 2 == 1) && (mr % 2 == 1);
    px[0][mr][mc] = r;
    px[1][mr][mc] = g;
    px[2][mr][mc] = b;
    if (comp) begin
      e = '0;
      for (int ch = 0; ch < 3; ch++) begin
        best = px[ch][mr-1][mc-1];
        e.idx[ch] = 2'd0;
        for (int p = 1; p < 4; p++) begin
          v = px[ch][mr-1+p/2][mc-1+p%2];
          if (v > best) begin
            best = v;
            e.idx[ch] = 2'(p);
          end
        end
        e.v[ch] = best;
      end
      e.fd = (mr == H - 1) && (mc == W - 1);
      q.push_back(e);
    end
    mc = (mc == W - 1) ? 0 : mc + 1;
    if (mc == 0) mr = (mr == H - 1) ? 0 : mr + 1;
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
    logic comp;
    model_px(r, g, b, comp);
    in_r = r;
    in_g = g;
    in_b = b;
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    chk("ack_latency", 64'(pool_ack), 64'(comp));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int mode, input bit gaps);
    logic [15:0] r, g, b;
    for (int i = 0; i < W * H; i++) begin
      case (mode)
        0: begin r = tp[i]; g = tp[i] + 16'd100; b = 16'd0; end
        1: begin r = 16'hFFFF; g = 16'hFFFF; b = 16'hFFFF; end
        2: begin r = 16'($urandom); g = 16'($urandom); b = 16'($urandom_range(0, 3)); end
        default: begin r = am[i]; g = am[15-i]; b = am[i] ^ 16'd1; end
      endcase
      send(r, g, b);
      if (gaps) idle($urandom_range(0, 3));
    end
  endtask

  always @(negedge clk) begin
    if (pool_ack) begin
      chk("ack_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("out_R", 64'(o_r), 64'(e.v[0]));
        chk("out_G", 64'(o_g), 64'(e.v[1]));
        chk("out_B", 64'(o_b), 64'(e.v[2]));
        chk("frame_done", 64'(frame_done), 64'(e.fd));
`ifdef MAXPOOL_ARGMAX_EN
        chk("pool_idx", 64'(pool_idx), 64'(e.idx));
`endif
      end
    end else begin
      if (frame_done) chk("frame_done_alone", 64'(frame_done), 64'd0);
    end
  end

  initial begin
    rst = 1'b1;
    ack = 1'b0;
    clr = 1'b0;
    in_r = '0;
    in_g = '0;
    in_b = '0;
    idle(3);
    chk("rst_R", 64'(o_r), 64'd0);
    chk("rst_G", 64'(o_g), 64'd0);
    chk("rst_B", 64'(o_b), 64'd0);
    chk("rst_ack", 64'(pool_ack), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
`ifdef MAXPOOL_ARGMAX_EN
    chk("rst_idx", 64'(pool_idx), 64'd0);
`endif
    rst = 1'b0;
    idle(1);
    send_frame(0, 1'b0);
    idle(2);
    send_frame(0, 1'b1);
    idle(2);
    send_frame(0, 1'b0);
    send_frame(1, 1'b0);
    idle(2);
    for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom), 16'($urandom));
    rst = 1'b1;
    in_r = 16'hFFFF;
    ack = 1'b1;
    idle(1);
    ack = 1'b0;
    chk("mid_rst_R", 64'(o_r), 64'd0);
    chk("mid_rst_G", 64'(o_g), 64'd0);
    chk("mid_rst_B", 64'(o_b), 64'd0);
    chk("mid_rst_ack", 64'(pool_ack), 64'd0);
    idle(1);
    rst = 1'b0;
    mc = 0;
    mr = 0;
    idle(1);
    chk("post_rst_ack", 64'(pool_ack), 64'd0);
    send_frame(2, 1'b1);
    idle(2);
    for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), 16'($urandom));
    in_r = 16'hFFFF;
    in_g = 16'hFFFF;
    in_b = 16'hFFFF;
    clr = 1'b1;
    ack = 1'b1;
    idle(1);
    clr = 1'b0;
    ack = 1'b0;
    chk("clr_ack", 64'(pool_ack), 64'd0);
    mc = 0;
    mr = 0;
    send_frame(2, 1'b0);
    idle(2);
    send_frame(3, 1'b1);
    idle(4);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
